// File: rtl/sysreg_file.sv
// Per-core system register file: eight registers with one-hot writes, same-cycle read bypass,
// a loadable free-running cycle counter in reg 7 and a 2-entry acknowledge queue for control-packet writes.
module sysreg_file #(
  parameter int unsigned            DATA_W    = 32,
  parameter logic [DATA_W-1:0]      CNT_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        sysreg_wen_vctr_i,
  input  logic              sysreg_w_terminate_i,
  input  logic [DATA_W-1:0] sysreg_wdata_i,
  input  logic [2:0]        rd_num_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              term_ack_valid_o,
  input  logic              term_ack_ready_i,
  output logic [2:0]        term_ack_num_o,
  output logic              stall_o,
  output logic              wen_err_o,
  output logic              ack_ovf_o
);

  logic [DATA_W-1:0] r_regs [8];
  logic [2:0]        r_q [2];
  logic              r_head;
  logic [1:0]        r_count;
  logic              r_wen_err;
  logic              r_ack_ovf;

  logic       w_onehot;
  logic       w_multi;
  logic [2:0] w_idx;
  logic       w_full;
  logic       w_deq;
  logic       w_enq;
  logic       w_ovf;
  logic       w_tail;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sysreg_wen_vctr_i[i]) w_idx = 3'(i);
    end
  end

  assign w_onehot = (sysreg_wen_vctr_i != 8'd0) &&
                    ((sysreg_wen_vctr_i & (sysreg_wen_vctr_i - 8'd1)) == 8'd0);
  assign w_multi  = (sysreg_wen_vctr_i != 8'd0) && !w_onehot;

  // A full queue still accepts a token when its head leaves in the same cycle.
  assign w_full = (r_count == 2'd2);
  assign w_deq  = (r_count != 2'd0) && term_ack_ready_i;
  assign w_enq  = sysreg_w_terminate_i && w_onehot && (!w_full || w_deq);
  assign w_ovf  = sysreg_w_terminate_i && w_onehot && w_full && !w_deq;
  assign w_tail = r_head ^ r_count[0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the register array sits in ordinary flops, so it is reset like any other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
      r_regs[7] <= CNT_RESET;
      r_q[0]    <= 3'd0;
      r_q[1]    <= 3'd0;
      r_head    <= 1'b0;
      r_count   <= 2'd0;
      r_wen_err <= 1'b0;
      r_ack_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (w_onehot && sysreg_wen_vctr_i[i]) r_regs[i] <= sysreg_wdata_i;
      end
      if (w_onehot && sysreg_wen_vctr_i[7]) r_regs[7] <= sysreg_wdata_i;
      else                                  r_regs[7] <= r_regs[7] + 1'b1;

      if (w_enq) r_q[w_tail] <= w_idx;
      if (w_deq) r_head <= ~r_head;
      r_count <= r_count + 2'(w_enq) - 2'(w_deq);

      if (w_multi) r_wen_err <= 1'b1;
      if (w_ovf)   r_ack_ovf <= 1'b1;
    end
  end

  assign rd_data_o = (w_onehot && sysreg_wen_vctr_i[rd_num_i]) ? sysreg_wdata_i : r_regs[rd_num_i];

  assign term_ack_valid_o = (r_count != 2'd0);
  assign term_ack_num_o   = r_q[r_head];
  assign stall_o          = w_full;
  assign wen_err_o        = r_wen_err;
  assign ack_ovf_o        = r_ack_ovf;

endmodule

// File: tb/tb_sysreg_file.sv
// Self-checking bench for sysreg_file: directed scenarios then randomized traffic,
// all compared against a behavioural model built from arrays and a queue.
module tb_sysreg_file;

  localparam int unsigned      DATA_W    = 32;
  localparam logic [31:0]      CNT_RESET = 32'd0;

  logic        clk;
  logic        rst;
  logic [7:0]  wen;
  logic        term;
  logic [31:0] wdata;
  logic [2:0]  rd_num;
  logic [31:0] rd_data;
  logic        ack_valid;
  logic        ack_ready;
  logic [2:0]  ack_num;
  logic        stall;
  logic        wen_err;
  logic        ack_ovf;

  sysreg_file #(.DATA_W(DATA_W), .CNT_RESET(CNT_RESET)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .sysreg_wen_vctr_i    (wen),
    .sysreg_w_terminate_i (term),
    .sysreg_wdata_i       (wdata),
    .rd_num_i             (rd_num),
    .rd_data_o            (rd_data),
    .term_ack_valid_o     (ack_valid),
    .term_ack_ready_i     (ack_ready),
    .term_ack_num_o       (ack_num),
    .stall_o              (stall),
    .wen_err_o            (wen_err),
    .ack_ovf_o            (ack_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Behavioural model
  logic [31:0] m_regs [8];
  int          m_q [$];
  bit          m_err, m_ovf, m_valid;

  // Values seen on the most recent sampled cycle, for directed spot checks
  logic [31:0] s_rd;
  logic        s_valid, s_stall, s_err, s_ovf;
  logic [2:0]  s_num;

  function automatic int idx_of(input logic [7:0] w);
    for (int i = 0; i < 8; i++) if (w[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic [7:0] w, input logic t,
                            input logic [31:0] d, input logic rdy);
    int  ones = $countones(w);
    int  size_before = m_q.size();
    bit  deq = (size_before > 0) && rdy;
    if (r) begin
      for (int i = 0; i < 7; i++) m_regs[i] = 32'd0;
      m_regs[7] = CNT_RESET;
      m_q.delete();
      m_err   = 0;
      m_ovf   = 0;
      m_valid = 1;
      return;
    end
    m_regs[7] = m_regs[7] + 32'd1;
    if (ones == 1) m_regs[idx_of(w)] = d;
    if (ones > 1) m_err = 1;
    if (deq) void'(m_q.pop_front());
    if (t && ones == 1) begin
      if (size_before < 2 || deq) m_q.push_back(idx_of(w));
      else                        m_ovf = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] w, input logic t,
                       input logic [31:0] d, input logic [2:0] rn, input logic rdy);
    logic [31:0] exp_rd;
    rst = r; wen = w; term = t; wdata = d; rd_num = rn; ack_ready = rdy;
    @(negedge clk);
    s_rd = rd_data; s_valid = ack_valid; s_num = ack_num;
    s_stall = stall; s_err = wen_err; s_ovf = ack_ovf;
    if (m_valid) begin
      exp_rd = ($countones(w) == 1 && w[rn]) ? d : m_regs[rn];
      check("rd_data", s_rd, exp_rd);
      check("ack_valid", 32'(s_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("ack_num", 32'(s_num), 32'(m_q[0]));
      check("stall", 32'(s_stall), 32'(m_q.size() == 2));
      check("wen_err", 32'(s_err), 32'(m_err));
      check("ack_ovf", 32'(s_ovf), 32'(m_ovf));
    end
    @(posedge clk);
    model_edge(r, w, t, d, rdy);
    #1;
  endtask

  task automatic idle(input logic [2:0] rn, input logic rdy);
    cycle(1'b0, 8'h00, 1'b0, 32'h0, rn, rdy);
  endtask

  initial begin
    m_valid = 0;
    rst = 1'b1; wen = '0; term = 1'b0; wdata = '0; rd_num = '0; ack_ready = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 8'h00, 1'b0, 32'h0, 3'd0, 1'b0);

    // Reset state of every register
    for (int i = 0; i < 8; i++) idle(3'(i), 1'b0);

    // 1: bypass on write to reg 2, visible next cycle, no ack
    cycle(1'b0, 8'h04, 1'b0, 32'hDEADBEEF, 3'd2, 1'b0);
    check("t1_bypass", s_rd, 32'hDEADBEEF);
    idle(3'd2, 1'b0);
    check("t1_reg2", s_rd, 32'hDEADBEEF);
    check("t1_noack", 32'(s_valid), 32'd0);

    // 2: counter counts from reset, loads, wraps
    cycle(1'b1, 8'h00, 1'b0, 32'h0, 3'd7, 1'b0);
    idle(3'd7, 1'b0); check("t2_cnt0", s_rd, 32'd0);
    idle(3'd7, 1'b0); check("t2_cnt1", s_rd, 32'd1);
    idle(3'd7, 1'b0); check("t2_cnt2", s_rd, 32'd2);
    cycle(1'b0, 8'h80, 1'b0, 32'hFFFFFFFE, 3'd7, 1'b0);
    check("t2_load_bypass", s_rd, 32'hFFFFFFFE);
    idle(3'd7, 1'b0); check("t2_k1", s_rd, 32'hFFFFFFFE);
    idle(3'd7, 1'b0); check("t2_k2", s_rd, 32'hFFFFFFFF);
    idle(3'd7, 1'b0); check("t2_wrap", s_rd, 32'd0);

    // 3: single token held while not ready, drained by one ready cycle
    cycle(1'b0, 8'h20, 1'b1, 32'h1234_5678, 3'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(3'd5, 1'b0);
      check("t3_valid", 32'(s_valid), 32'd1);
      check("t3_num", 32'(s_num), 32'd5);
    end
    idle(3'd5, 1'b1);
    idle(3'd5, 1'b0);
    check("t3_drained", 32'(s_valid), 32'd0);

    // 4: fill, overflow, drain in order
    cycle(1'b0, 8'h01, 1'b1, 32'hA0, 3'd0, 1'b0);
    cycle(1'b0, 8'h02, 1'b1, 32'hA1, 3'd1, 1'b0);
    cycle(1'b0, 8'h04, 1'b1, 32'hA2, 3'd2, 1'b0);
    check("t4_stall", 32'(s_stall), 32'd1);
    idle(3'd2, 1'b1);
    check("t4_reg2", s_rd, 32'hA2);
    check("t4_ovf", 32'(s_ovf), 32'd1);
    check("t4_first", 32'(s_num), 32'd0);
    idle(3'd0, 1'b1);
    check("t4_second", 32'(s_num), 32'd1);
    idle(3'd0, 1'b0);
    check("t4_empty", 32'(s_valid), 32'd0);

    // 5: multi-bit wen with terminate
    cycle(1'b0, 8'h03, 1'b1, 32'h5555, 3'd0, 1'b0);
    idle(3'd0, 1'b0);
    check("t5_reg0", s_rd, 32'hA0);
    check("t5_err", 32'(s_err), 32'd1);
    check("t5_notoken", 32'(s_valid), 32'd0);

    // 6: reset with a full queue and a write in flight
    cycle(1'b0, 8'h08, 1'b1, 32'h33, 3'd3, 1'b0);
    cycle(1'b0, 8'h10, 1'b1, 32'h44, 3'd4, 1'b0);
    cycle(1'b1, 8'h40, 1'b1, 32'h66, 3'd6, 1'b0);
    idle(3'd6, 1'b0);
    check("t6_valid", 32'(s_valid), 32'd0);
    check("t6_stall", 32'(s_stall), 32'd0);
    check("t6_reg6", s_rd, 32'd0);
    check("t6_err", 32'(s_err), 32'd0);
    check("t6_ovf", 32'(s_ovf), 32'd0);
    for (int i = 0; i < 7; i++) idle(3'(i), 1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] w;
      int sel = $urandom_range(0, 9);
      if (sel < 3)      w = 8'h00;
      else if (sel < 8) w = 8'h01 << $urandom_range(0, 7);
      else              w = 8'($urandom);
      cycle(($urandom_range(0, 99) == 0), w, 1'($urandom), $urandom,
            3'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
